// File: rtl/dp_inst_encoder.sv
// rtl/dp_inst_encoder.sv - ARM data-processing instruction encoder with legality check and output FIFO (optional stats: DP_ENC_STATS_EN)
module dp_inst_encoder #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_form,
  input  logic [3:0]       in_cond,
  input  logic [3:0]       in_op,
  input  logic             in_s,
  input  logic [3:0]       in_rn,
  input  logic [3:0]       in_rd,
  input  logic [3:0]       in_rm,
  input  logic [3:0]       in_rs,
  input  logic [1:0]       in_type,
  input  logic [4:0]       in_imm5,
  input  logic [3:0]       in_rot,
  input  logic [7:0]       in_imm8,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             err,
  output logic [1:0]       err_cause
`ifdef DP_ENC_STATS_EN
  ,
  output logic [CNT_W-1:0] enc_cnt,
  output logic [CNT_W-1:0] rej_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = DEPTH[PW:0];

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [31:0]   word;
  logic [1:0]    cause;
  logic          push;
  logic          legal;
  logic          wr_en;
  logic          rd_en;

  // Full/empty come straight from the count register, so in_ready never sees out_ready.
  assign in_ready  = (count < DEPTH_C);
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;

  assign push  = in_valid & in_ready;
  assign legal = (cause == 2'd0);
  assign wr_en = push & legal;
  assign rd_en = out_valid & out_ready;

  // Pack the requested form and apply the decoder's acceptance rules in priority order.
  always_comb begin
    word  = '0;
    cause = 2'd0;
    word[31:28] = in_cond;
    word[24:21] = in_op;
    word[20]    = in_s;
    word[19:16] = in_rn;
    word[15:12] = in_rd;
    case (in_form)
      2'd0: word[11:0] = {in_imm5, in_type, 1'b0, in_rm};
      2'd1: word[11:0] = {in_rs, 1'b0, in_type, 1'b1, in_rm};
      2'd2: begin
        word[25]   = 1'b1;
        word[11:0] = {in_rot, in_imm8};
      end
      default: word[11:0] = '0;
    endcase
    if (in_form == 2'd3) begin
      cause = 2'd1;
    end else if ((in_op[3:2] == 2'b10) && !in_s) begin
      cause = 2'd2;
    end else if ((in_rd == 4'd15) &&
                 !((in_rn == 4'd14) && in_s && ((in_op == 4'hD) || (in_op == 4'h2)))) begin
      cause = 2'd3;
    end
  end

  // Storage array needs no reset; out_data is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= word;
    end
  end

  // Pointers, occupancy and rejection reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err       <= 1'b0;
      err_cause <= 2'd0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
      err <= push & !legal;
      if (push && !legal) begin
        err_cause <= cause;
      end
    end
  end

`ifdef DP_ENC_STATS_EN
  // Saturating counts of accepted legal and rejected requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enc_cnt <= '0;
      rej_cnt <= '0;
    end else begin
      if (wr_en && (enc_cnt != '1)) begin
        enc_cnt <= enc_cnt + CNT_W'(1);
      end
      if (push && !legal && (rej_cnt != '1)) begin
        rej_cnt <= rej_cnt + CNT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dp_inst_encoder.sv
// tb/tb_dp_inst_encoder.sv - self-checking bench for dp_inst_encoder
module tb_dp_inst_encoder;

  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_form;
  logic [3:0]       in_cond;
  logic [3:0]       in_op;
  logic             in_s;
  logic [3:0]       in_rn;
  logic [3:0]       in_rd;
  logic [3:0]       in_rm;
  logic [3:0]       in_rs;
  logic [1:0]       in_type;
  logic [4:0]       in_imm5;
  logic [3:0]       in_rot;
  logic [7:0]       in_imm8;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             err;
  logic [1:0]       err_cause;
`ifdef DP_ENC_STATS_EN
  logic [CNT_W-1:0] enc_cnt;
  logic [CNT_W-1:0] rej_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dp_inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_form(in_form), .in_cond(in_cond), .in_op(in_op), .in_s(in_s),
    .in_rn(in_rn), .in_rd(in_rd), .in_rm(in_rm), .in_rs(in_rs),
    .in_type(in_type), .in_imm5(in_imm5), .in_rot(in_rot), .in_imm8(in_imm8),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .err(err), .err_cause(err_cause)
`ifdef DP_ENC_STATS_EN
    , .enc_cnt(enc_cnt), .rej_cnt(rej_cnt)
`endif
  );

  typedef struct {
    logic [1:0] form;
    logic [3:0] cond, op;
    logic       s;
    logic [3:0] rn, rd, rm, rs;
    logic [1:0] typ;
    logic [4:0] imm5;
    logic [3:0] rot;
    logic [7:0] imm8;
  } req_t;

  typedef struct {
    req_t        r;
    logic        legal;
    logic [31:0] word;
    logic [1:0]  cause;
  } vec_t;

  function automatic req_t mk(int form, int cond, int op, int s, int rn, int rd,
                              int rm, int rs, int typ, int imm5, int rot, int imm8);
    req_t r;
    r.form = form[1:0]; r.cond = cond[3:0]; r.op = op[3:0]; r.s = s[0];
    r.rn = rn[3:0]; r.rd = rd[3:0]; r.rm = rm[3:0]; r.rs = rs[3:0];
    r.typ = typ[1:0]; r.imm5 = imm5[4:0]; r.rot = rot[3:0]; r.imm8 = imm8[7:0];
    return r;
  endfunction

  // Reference encoding built with arithmetic weights of each field position.
  function automatic logic [31:0] model_word(req_t r);
    longint w;
    w = longint'(r.cond) * 268435456 + longint'(r.op) * 2097152 + longint'(r.s) * 1048576
      + longint'(r.rn) * 65536 + longint'(r.rd) * 4096;
    if (r.form == 2)
      w += 33554432 + longint'(r.rot) * 256 + longint'(r.imm8);
    else if (r.form == 1)
      w += longint'(r.rs) * 256 + longint'(r.typ) * 32 + 16 + longint'(r.rm);
    else
      w += longint'(r.imm5) * 128 + longint'(r.typ) * 32 + longint'(r.rm);
    return w[31:0];
  endfunction

  function automatic int model_cause(req_t r);
    bit is_cmp, exc_ret;
    is_cmp  = (r.op >= 8) && (r.op <= 11);
    exc_ret = (r.rn == 14) && r.s && ((r.op == 13) || (r.op == 2));
    if (r.form == 3) return 1;
    if (is_cmp && !r.s) return 2;
    if (r.rd == 15 && !exc_ret) return 3;
    return 0;
  endfunction

  task automatic drive(req_t r);
    in_form = r.form; in_cond = r.cond; in_op = r.op; in_s = r.s;
    in_rn = r.rn; in_rd = r.rd; in_rm = r.rm; in_rs = r.rs;
    in_type = r.typ; in_imm5 = r.imm5; in_rot = r.rot; in_imm8 = r.imm8;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic req_t rand_req();
    req_t r;
    r.form = 2'($urandom_range(0, 9) == 0 ? 3 : $urandom_range(0, 2));
    r.cond = 4'($urandom); r.op = 4'($urandom); r.s = 1'($urandom);
    r.rn = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom);
    r.rd = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom);
    r.rm = 4'($urandom); r.rs = 4'($urandom); r.typ = 2'($urandom);
    r.imm5 = 5'($urandom); r.rot = 4'($urandom); r.imm8 = 8'($urandom);
    return r;
  endfunction

  vec_t   vec [8];
  req_t   ra, rb, rc, rr;
  logic [31:0] q[$];
  bit     exp_err;
  int     exp_cause;
  bit     acc, pop;
  int     c;

  initial begin
    vec[0] = '{mk(0, 14, 4, 0, 1, 2, 4, 0, 1, 3, 0, 0), 1'b1, 32'hE08121A4, 2'd0};
    vec[1] = '{mk(2, 14, 10, 1, 3, 0, 0, 0, 0, 0, 0, 5), 1'b1, 32'hE3530005, 2'd0};
    vec[2] = '{mk(2, 14, 10, 0, 3, 0, 0, 0, 0, 0, 0, 5), 1'b0, 32'h0, 2'd2};
    vec[3] = '{mk(2, 14, 2, 1, 14, 15, 0, 0, 0, 0, 0, 4), 1'b1, 32'hE25EF004, 2'd0};
    vec[4] = '{mk(0, 14, 13, 1, 0, 15, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0, 2'd3};
    vec[5] = '{mk(1, 0, 0, 1, 5, 6, 8, 7, 2, 0, 0, 0), 1'b1, 32'h00156758, 2'd0};
    vec[6] = '{mk(3, 14, 8, 0, 0, 15, 0, 0, 0, 0, 0, 0), 1'b0, 32'h0, 2'd1};
    vec[7] = '{mk(0, 14, 13, 1, 14, 15, 0, 0, 0, 0, 0, 0), 1'b1, 32'hE1BEF000, 2'd0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_err", 32'(err), 0);
    chk("rst_err_cause", 32'(err_cause), 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      drive(vec[i].r);
      in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vec[i].legal));
      chk($sformatf("vec%0d_err", i), 32'(err), 32'(!vec[i].legal));
      if (vec[i].legal) chk($sformatf("vec%0d_data", i), out_data, vec[i].word);
      else chk($sformatf("vec%0d_cause", i), 32'(err_cause), 32'(vec[i].cause));
      tick();
      chk($sformatf("vec%0d_drained", i), 32'(out_valid), 0);
      chk($sformatf("vec%0d_err_gone", i), 32'(err), 0);
    end

    // Backpressure: fill, stall a third request, then drain in order.
    ra = mk(0, 1, 1, 0, 1, 2, 3, 0, 0, 1, 0, 0);
    rb = mk(1, 2, 4, 1, 4, 5, 6, 7, 3, 0, 0, 0);
    rc = mk(2, 3, 12, 0, 8, 9, 0, 0, 0, 0, 5, 8'hA5);
    out_ready = 1'b0; in_valid = 1'b1;
    drive(ra); tick();
    drive(rb); tick();
    chk("bp_full_in_ready", 32'(in_ready), 0);
    drive(rc); tick();
    chk("bp_stall_in_ready", 32'(in_ready), 0);
    chk("bp_head_a", out_data, model_word(ra));
    out_ready = 1'b1; tick();
    chk("bp_in_ready_back", 32'(in_ready), 1);
    chk("bp_head_b", out_data, model_word(rb));
    tick();
    in_valid = 1'b0;
    chk("bp_pushpop_valid", 32'(out_valid), 1);
    chk("bp_head_c", out_data, model_word(rc));
    tick();
    chk("bp_empty", 32'(out_valid), 0);

    // Reset with two words queued and a rejection on record.
    out_ready = 1'b0; in_valid = 1'b1;
    drive(mk(0, 14, 13, 1, 0, 15, 0, 0, 0, 0, 0, 0)); tick();
    drive(ra); tick();
    drive(rb); tick();
    in_valid = 1'b0;
    chk("pre_rst_cause", 32'(err_cause), 3);
    chk("pre_rst_full", 32'(in_ready), 0);
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; drive(rc);
    tick();
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_cause", 32'(err_cause), 0);
    chk("mid_rst_err", 32'(err), 0);
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
    chk("post_rst_empty", 32'(out_valid), 0);

    // Random traffic against the queue model.
    exp_err = 1'b0; exp_cause = 0;
    for (int n = 0; n < 600; n++) begin
      chk("rnd_out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (q.size() != 0) chk("rnd_out_data", out_data, q[0]);
      chk("rnd_in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("rnd_err", 32'(err), 32'(exp_err));
      chk("rnd_err_cause", 32'(err_cause), 32'(exp_cause));
      rr = rand_req();
      drive(rr);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && (q.size() < DEPTH);
      pop = out_ready && (q.size() != 0);
      tick();
      exp_err = 1'b0;
      if (pop) void'(q.pop_front());
      if (acc) begin
        c = model_cause(rr);
        if (c == 0) q.push_back(model_word(rr));
        else begin
          exp_err = 1'b1;
          exp_cause = c;
        end
      end
    end
    in_valid = 1'b0;

`ifdef DP_ENC_STATS_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("stats_rst_enc", 32'(enc_cnt), 0);
    chk("stats_rst_rej", 32'(rej_cnt), 0);
    out_ready = 1'b1; in_valid = 1'b1; drive(ra);
    for (int n = 0; n < 300; n++) tick();
    in_valid = 1'b0;
    drive(mk(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)); in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    chk("stats_enc_sat", 32'(enc_cnt), 255);
    chk("stats_rej_one", 32'(rej_cnt), 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
